amm_test_sequencer: RTL
=======================

// Module: amm_test_sequencer
// PURPOSE
//  Avalon-MM master that runs one memory-checker test: write bursts, read bursts, or write-then-read over a linear address range.
//  Sits between the CSR block (start/config) and the memory interface; measure_block snoops the same bus.
//  Caps outstanding read bursts at MAX_RD_OUTST so the delay-measurement counters never overflow.
// PARAMETERS
//  ADDR_W        31  Avalon word-address width
//  BURST_W       11  burstcount width
//  DATA_W        128 data width, multiple of 32
//  MAX_RD_OUTST  4   max read bursts accepted but not fully returned; power of 2, >=1
// PORTS
//  clk_i            in   1              clock
//  rst_i            in   1              reset, synchronous, active-high
//  test_start_i     in   1              start pulse; ignored while busy_o=1
//  test_mode_i      in   2              0=write only, 1=read only, 2=write then read, 3=reserved (treated as 0)
//  start_addr_i     in   ADDR_W         first burst address
//  burst_len_i      in   BURST_W        beats per burst; 0 treated as 1
//  trans_amount_i   in   32             bursts per phase
//  busy_o           out  1              test in progress
//  done_o           out  1              1-cycle pulse at test end
//  address_o        out  ADDR_W         Avalon address
//  read_o           out  1              Avalon read
//  write_o          out  1              Avalon write
//  burstcount_o     out  BURST_W        Avalon burstcount
//  byteenable_o     out  DATA_W/8       all ones when write_o/read_o high, else 0
//  writedata_o      out  DATA_W         {DATA_W/32{beat_index[31:0]}}
//  waitrequest_i    in   1              Avalon waitrequest
//  readdatavalid_i  in   1              Avalon readdatavalid
// BEHAVIOUR
//  Reset: FSM=IDLE, all outputs 0, counters 0; mid-test reset aborts with no done_o pulse.
//  Config (mode, addr, len, amount) latched on accepted test_start_i; later input changes have no effect.
//  FSM: IDLE -> WR (mode 0/2) | RD (mode 1) ; WR -> RD (mode 2) | FIN ; RD -> RD_DRAIN ; RD_DRAIN -> FIN ; FIN -> IDLE.
//  amount=0: IDLE -> FIN -> IDLE, no bus cycles, done_o 2 cycles after start.
//  Latency: start at cycle N -> write_o/read_o may assert at N+1; busy_o=1 from N+1 until cycle of done_o inclusive.
//  Handshake: cmd accepted when (read_o|write_o) && !waitrequest_i; all outputs held stable while waitrequest_i=1.
//  WR: write_o held for burst_len beats; address_o/burstcount_o constant within burst; beat_index counts accepted beats
//    from 0 for the whole phase (wraps 2^32); next burst may start the cycle after last beat accepted (no bubble required).
//  Address: after each burst addr += burst_len, modulo 2^ADDR_W (silent wrap); RD phase restarts at start_addr.
//  RD: read_o asserted only if outst_cnt < MAX_RD_OUTST; one cycle read_o per burst (until accepted).
//  outst_cnt: +1 on accepted read; -1 when ret_beat reaches burst_len on readdatavalid_i; simultaneous +1/-1 -> unchanged.
//  ret_beat: counts readdatavalid_i, resets to 0 on last beat of burst; readdatavalid_i in IDLE/WR ignored.
//  RD -> RD_DRAIN after trans_amount reads accepted; RD_DRAIN -> FIN when outst_cnt=0.
//  WR done (mode 0) after last write beat accepted -> FIN; done_o high in FIN for exactly 1 cycle.
//  Widths: burst/beat counters BURST_W+1 bits; transaction counters 32 bits; no saturation needed.
// TESTING
//  mode0, addr 0x100, len 4, amount 3, no waitrequest -> 12 write beats, addresses 0x100/0x104/0x108, data 0..11, done_o once.
//  mode1, len 2, amount 8, readdatavalid delayed 40 cycles -> read_o never issued with 4 outstanding; 16 beats; done after last.
//  mode2, waitrequest random 50% -> outputs stable under waitrequest, write phase then reads from start_addr, counts match.
//  addr 2^ADDR_W-2, len 4, amount 2 -> second burst address 2 (wrap); amount 0 -> no bus cycle, done_o at start+2.
//  reset asserted mid-RD with 3 outstanding -> next cycle all outputs 0, no done_o; new start runs cleanly.
//  test_start_i pulsed while busy -> ignored; final read return and new read accept same cycle -> outst_cnt unchanged.

Source files
------------

// File: rtl/amm_test_sequencer.sv
// Avalon-MM burst master for one memory-checker test: write, read, or write-then-read
// over a linear address range, with in-flight read bursts capped at MAX_RD_OUTST.
module amm_test_sequencer #(
  parameter int ADDR_W       = 31,
  parameter int BURST_W      = 11,
  parameter int DATA_W       = 128,
  parameter int MAX_RD_OUTST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_start_i,
  input  logic [1:0]            test_mode_i,
  input  logic [ADDR_W-1:0]     start_addr_i,
  input  logic [BURST_W-1:0]    burst_len_i,
  input  logic [31:0]           trans_amount_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_W-1:0]     address_o,
  output logic                  read_o,
  output logic                  write_o,
  output logic [BURST_W-1:0]    burstcount_o,
  output logic [DATA_W/8-1:0]   byteenable_o,
  output logic [DATA_W-1:0]     writedata_o,
  input  logic                  waitrequest_i,
  input  logic                  readdatavalid_i
);

  localparam int OUTST_W = $clog2(MAX_RD_OUTST) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_DRAIN,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   start_addr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  len_q;
  logic [31:0]         amount_q;
  logic [BURST_W:0]    wr_beat_q;
  logic [BURST_W:0]    ret_beat_q;
  logic [31:0]         burst_cnt_q;
  logic [31:0]         beat_idx_q;
  logic [OUTST_W-1:0]  outst_q;
  logic                done_q;

  logic                start_ok;
  logic                wr_acc;
  logic                rd_acc;
  logic                rd_ret;
  logic                ret_last;
  logic                wr_last_beat;
  logic                last_burst;
  logic                act_wr;
  logic                act_rd;
  logic [BURST_W:0]    len_m1;

  // done_o is registered from FIN, so the test stays busy through the done cycle
  // and a start arriving on that cycle is still ignored.
  assign start_ok     = (state_q == S_IDLE) && !done_q && test_start_i;
  assign len_m1       = {1'b0, len_q} - {{BURST_W{1'b0}}, 1'b1};
  assign wr_acc       = write_o && !waitrequest_i;
  assign rd_acc       = read_o && !waitrequest_i;
  assign wr_last_beat = (wr_beat_q == len_m1);
  assign last_burst   = (burst_cnt_q == amount_q - 32'd1);
  assign rd_ret       = readdatavalid_i && ((state_q == S_RD) || (state_q == S_RD_DRAIN));
  assign ret_last     = rd_ret && (ret_beat_q == len_m1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if (trans_amount_i == 32'd0) begin
            state_d = S_FIN;
          end else if (test_mode_i == 2'd1) begin
            state_d = S_RD;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_WR: begin
        if (wr_acc && wr_last_beat && last_burst) begin
          state_d = (mode_q == 2'd2) ? S_RD : S_FIN;
        end
      end
      S_RD: begin
        if (rd_acc && last_burst) begin
          state_d = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so they cannot move while waitrequest is high.
  always_comb begin
    act_wr       = (state_q == S_WR);
    act_rd       = (state_q == S_RD) && (outst_q < OUTST_W'(MAX_RD_OUTST));
    write_o      = act_wr;
    read_o       = act_rd;
    address_o    = (act_wr || act_rd) ? addr_q : '0;
    burstcount_o = (act_wr || act_rd) ? len_q : '0;
    byteenable_o = (act_wr || act_rd) ? '1 : '0;
    writedata_o  = act_wr ? {(DATA_W/32){beat_idx_q}} : '0;
    busy_o       = (state_q != S_IDLE) || done_q;
    done_o       = done_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q       <= '0;
      start_addr_q <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      amount_q     <= '0;
      wr_beat_q    <= '0;
      ret_beat_q   <= '0;
      burst_cnt_q  <= '0;
      beat_idx_q   <= '0;
      outst_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state_q == S_FIN);
      if (start_ok) begin
        mode_q       <= (test_mode_i == 2'd3) ? 2'd0 : test_mode_i;
        start_addr_q <= start_addr_i;
        addr_q       <= start_addr_i;
        len_q        <= (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
        amount_q     <= trans_amount_i;
        wr_beat_q    <= '0;
        burst_cnt_q  <= '0;
        beat_idx_q   <= '0;
      end
      if (wr_acc) begin
        beat_idx_q <= beat_idx_q + 32'd1;
        if (wr_last_beat) begin
          wr_beat_q <= '0;
          if (last_burst) begin
            addr_q      <= start_addr_q;
            burst_cnt_q <= '0;
          end else begin
            addr_q      <= addr_q + ADDR_W'(len_q);
            burst_cnt_q <= burst_cnt_q + 32'd1;
          end
        end else begin
          wr_beat_q <= wr_beat_q + (BURST_W+1)'(1);
        end
      end
      if (rd_acc) begin
        addr_q      <= addr_q + ADDR_W'(len_q);
        burst_cnt_q <= burst_cnt_q + 32'd1;
      end
      if (rd_ret) begin
        ret_beat_q <= ret_last ? '0 : ret_beat_q + (BURST_W+1)'(1);
      end
      case ({rd_acc, ret_last})
        2'b10:   outst_q <= outst_q + OUTST_W'(1);
        2'b01:   outst_q <= outst_q - OUTST_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

endmodule
